writeback_unit: RTL and testbench
=================================

# writeback_unit

Collects completed results from two execution sources, a single-cycle ALU path (A) and a multi-cycle load/mul-div path (M), buffers each in a small FIFO, and arbitrates them onto the single register-file write port, one write per cycle. It also holds the destination-register scoreboard that the issue stage checks for RAW/WAW hazards. It sits between the execute units and the register file; its write-port outputs connect directly to the register file's write select, data and enable inputs.

## Interface
- XLEN, 64, data width of results and write port
- FIFO_DEPTH, 2, entries per source FIFO; power of two, minimum 2
- i_clk  in  1  clock
- i_reset  in  1  synchronous reset, active-high
- i_a_valid  in  1  ALU result valid
- o_a_ready  out  1  ALU FIFO can accept
- i_a_rd  in  5  ALU destination register
- i_a_data  in  XLEN  ALU result
- i_m_valid  in  1  M-path result valid
- o_m_ready  out  1  M FIFO can accept
- i_m_rd  in  5  M-path destination register
- i_m_data  in  XLEN  M-path result
- i_issue_valid  in  1  issue stage reserves a destination this cycle
- i_issue_rd  in  5  destination being reserved
- o_busy  out  32  scoreboard; bit r = write to xr pending
- o_sel_w  out  5  register-file write select
- o_dat_w  out  XLEN  register-file write data
- o_we  out  1  register-file write enable
- o_idle  out  1  both FIFOs empty and o_we low

## Operation
- Handshake per source: transfer when valid && ready; ready = FIFO not full. No combinational path from valid to ready. Payload must be held stable while valid && !ready.
- Each FIFO: FIFO_DEPTH entries of {rd, data}, circular pointers with an extra wrap bit. Push and pop in the same cycle are legal when full; the full flag is evaluated before the pop.
- Arbiter: one pop per cycle. Only one head non-empty: grant it. Both heads non-empty: round-robin; grant the source not granted at the last two-way conflict. The round-robin pointer updates only on conflicts.
- Granted entry is registered into o_sel_w/o_dat_w. o_we = 1 only if the granted rd != 0. Entries with rd = 0 are popped and discarded, with o_we = 0 and o_sel_w/o_dat_w still updated.
- Scoreboard:
  - i_issue_valid with i_issue_rd != 0 sets o_busy[rd] at the next edge.
  - A cycle with o_we = 1 clears o_busy[o_sel_w] at the next edge.
  - Set and clear of the same register in one cycle: set wins.
  - o_busy[0] is constant 0.
- The issue stage must not reserve a register whose busy bit is set (no WAW in flight). Under that rule, write order between sources is irrelevant. No checking is done here.

## Timing
- Reset values: o_we = 0, o_sel_w = 0, o_dat_w = 0, o_busy = 0, o_a_ready = o_m_ready = 1, o_idle = 1, FIFOs empty, round-robin pointer = A.
- Latency: accept at edge N → entry is FIFO head in cycle N+1 → o_we asserted in cycle N+2 (2 cycles, no contention).
- Busy clears one cycle after o_we, so the register file's write-through bypass covers the cycle in which o_busy is still set.
- Throughput: one write per cycle sustained. Each source sustains 1/cycle alone, or 1/2 cycle each when both are saturated.
- Reset mid-operation: FIFO contents, the pending write and scoreboard bits are all discarded. No write occurs in the cycle after reset.

## Structure
- Shared core package holds:
  - REG_ADDR_W = 5
  - XLEN default
  - the wb_entry_t packed struct {rd[4:0], data[XLEN-1:0]}
- One sub-module, wb_fifo: parameterized synchronous FIFO of wb_entry_t with push/pop/full/empty, instantiated twice.
- Arbiter, output register and scoreboard live in the top module.

## Test plan
- Single ALU write: A pushes rd = 5, data = 0x1234 at cycle 0 → o_we = 1, o_sel_w = 5, o_dat_w = 0x1234 in cycle 2. o_busy[5], reserved earlier, clears in cycle 3.
- Contention: A and M both push every cycle (A rd = 1..4, M rd = 9..12) → writes strictly alternate A/M starting with A; o_a_ready drops once the FIFO is full; no entry is lost or duplicated.
- rd = 0: A pushes rd = 0, data = 0xFFFF → entry is popped, o_we stays 0, o_busy unchanged; issue of rd = 0 never sets o_busy[0].
- Scoreboard collision: o_busy[7] set, write to x7 in cycle k, and new issue of rd = 7 in cycle k → o_busy[7] remains 1 at cycle k+1.
- Full FIFO boundary: M FIFO full and M valid held while popping → push and pop occur in the same cycle only after ready rises; payload held stable while stalled is accepted exactly once.
- Reset mid-flight: both FIFOs non-empty and o_busy = 0x00F0, assert i_reset for 1 cycle → o_we = 0, o_busy = 0, o_idle = 1; no stale write appears afterward.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg
//   Shared definitions for the writeback slice: register address width,
//   result width and the {rd, data} entry carried through the source FIFOs.
package writeback_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if
//   Bundles every non-clock signal of writeback_unit.
//   ALU source   : i_a_valid / o_a_ready / i_a_rd / i_a_data
//   M source     : i_m_valid / o_m_ready / i_m_rd / i_m_data
//   Issue        : i_issue_valid / i_issue_rd, scoreboard o_busy
//   Write port   : o_sel_w / o_dat_w / o_we, status o_idle
//   master = execute/issue side, slave = writeback_unit.
interface writeback_unit_if
  import writeback_unit_pkg::*;
#(
  parameter int DATA_W = XLEN
);

  logic                  i_a_valid;
  logic                  o_a_ready;
  logic [REG_ADDR_W-1:0] i_a_rd;
  logic [DATA_W-1:0]     i_a_data;

  logic                  i_m_valid;
  logic                  o_m_ready;
  logic [REG_ADDR_W-1:0] i_m_rd;
  logic [DATA_W-1:0]     i_m_data;

  logic                  i_issue_valid;
  logic [REG_ADDR_W-1:0] i_issue_rd;
  logic [31:0]           o_busy;

  logic [REG_ADDR_W-1:0] o_sel_w;
  logic [DATA_W-1:0]     o_dat_w;
  logic                  o_we;
  logic                  o_idle;

  modport master (
    output i_a_valid, i_a_rd, i_a_data,
    output i_m_valid, i_m_rd, i_m_data,
    output i_issue_valid, i_issue_rd,
    input  o_a_ready, o_m_ready, o_busy, o_sel_w, o_dat_w, o_we, o_idle
  );

  modport slave (
    input  i_a_valid, i_a_rd, i_a_data,
    input  i_m_valid, i_m_rd, i_m_data,
    input  i_issue_valid, i_issue_rd,
    output o_a_ready, o_m_ready, o_busy, o_sel_w, o_dat_w, o_we, o_idle
  );

endinterface

// File: rtl/writeback_unit_wb_fifo.sv
// wb_fifo
//   Synchronous FIFO of wb_entry_t with a combinational head view.
//   Ports: i_clk, i_reset (sync, active-high), push/push_data (ignored when
//   full), pop (ignored when empty), head, full, empty.
//   Pointers carry an extra wrap bit so full and empty are distinguishable
//   without a counter.
module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // Full is judged on the pre-pop state, so a full FIFO refuses a push
  // even in a cycle where it is also popped.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit
//   Buffers results from the ALU (A) and multi-cycle (M) paths in one FIFO
//   each, arbitrates one entry per cycle onto the register-file write port
//   and keeps the destination-register busy scoreboard for the issue stage.
//   Ports: i_clk, i_reset (sync, active-high), bus (writeback_unit_if.slave).
//   Write port is registered: accept at edge N, o_we in cycle N+2.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  writeback_unit_if.slave bus
);

  wb_entry_t a_in, m_in, a_head, m_head, granted;
  logic      a_full, a_empty, m_full, m_empty;
  logic      grant_a, grant_m, conflict;

  // 1 = M wins the next two-way conflict, 0 = A wins.
  logic      rr_m_reg, rr_m_next;

  logic                  we_reg, we_next;
  logic [REG_ADDR_W-1:0] sel_reg, sel_next;
  logic [XLEN-1:0]       dat_reg, dat_next;
  logic [31:0]           busy_reg, busy_next;

  assign a_in = '{rd: bus.i_a_rd, data: bus.i_a_data};
  assign m_in = '{rd: bus.i_m_rd, data: bus.i_m_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_a_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .push     (bus.i_a_valid),
    .push_data(a_in),
    .pop      (grant_a),
    .head     (a_head),
    .full     (a_full),
    .empty    (a_empty)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_m_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .push     (bus.i_m_valid),
    .push_data(m_in),
    .pop      (grant_m),
    .head     (m_head),
    .full     (m_full),
    .empty    (m_empty)
  );

  always_comb begin
    conflict  = !a_empty && !m_empty;
    grant_a   = !a_empty && (m_empty || !rr_m_reg);
    grant_m   = !m_empty && !grant_a;
    granted   = grant_a ? a_head : m_head;
    // After a conflict the loser gets priority next time.
    rr_m_next = conflict ? grant_a : rr_m_reg;

    we_next  = 1'b0;
    sel_next = sel_reg;
    dat_next = dat_reg;
    if (grant_a || grant_m) begin
      // x0 writes are drained but never reach the register file.
      we_next  = (granted.rd != '0);
      sel_next = granted.rd;
      dat_next = granted.data;
    end
  end

  // Scoreboard: a new reservation beats a same-cycle completion.
  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    assign busy_next[gi] =
        (bus.i_issue_valid && (bus.i_issue_rd == REG_ADDR_W'(gi))) ||
        (busy_reg[gi] && !(we_reg && (sel_reg == REG_ADDR_W'(gi))));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_m_reg <= 1'b0;
      we_reg   <= 1'b0;
      sel_reg  <= '0;
      dat_reg  <= '0;
      busy_reg <= '0;
    end else begin
      rr_m_reg <= rr_m_next;
      we_reg   <= we_next;
      sel_reg  <= sel_next;
      dat_reg  <= dat_next;
      busy_reg <= busy_next;
    end
  end

  assign bus.o_a_ready = !a_full;
  assign bus.o_m_ready = !m_full;
  assign bus.o_we      = we_reg;
  assign bus.o_sel_w   = sel_reg;
  assign bus.o_dat_w   = dat_reg;
  assign bus.o_busy    = busy_reg;
  assign bus.o_idle    = a_empty && m_empty && !we_reg;

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit
//   Directed stimulus against writeback_unit. A queue-level reference model
//   predicts every output each cycle; directed literal checks pin the model
//   to the hand-computed scenarios.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  localparam int FD = 2;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  writeback_unit_if #(.DATA_W(XLEN)) bus ();

  writeback_unit #(.FIFO_DEPTH(FD)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            qa[$];
  ent_t            qm[$];
  bit              m_rr_m;
  bit              m_we;
  logic [4:0]      m_sel;
  logic [XLEN-1:0] m_dat;
  logic [31:0]     m_busy;
  int              wr_log[$];
  bit              chk_en = 1'b0;

  ent_t e_pop;
  bit   had_pop, pre_a_ok, pre_m_ok;

  always @(posedge i_clk) begin
    if (i_reset) begin
      qa.delete();
      qm.delete();
      m_rr_m = 1'b0;
      m_we   = 1'b0;
      m_sel  = '0;
      m_dat  = '0;
      m_busy = '0;
      chk_en = 1'b1;
    end else begin
      pre_a_ok = (qa.size() < FD);
      pre_m_ok = (qm.size() < FD);
      had_pop  = 1'b0;
      if (qa.size() > 0 && qm.size() > 0) begin
        if (m_rr_m) e_pop = qm.pop_front();
        else        e_pop = qa.pop_front();
        m_rr_m  = !m_rr_m;
        had_pop = 1'b1;
      end else if (qa.size() > 0) begin
        e_pop = qa.pop_front();
        had_pop = 1'b1;
      end else if (qm.size() > 0) begin
        e_pop = qm.pop_front();
        had_pop = 1'b1;
      end
      if (m_we) m_busy[m_sel] = 1'b0;
      if (bus.i_issue_valid && bus.i_issue_rd != 5'd0) m_busy[bus.i_issue_rd] = 1'b1;
      if (had_pop) begin
        m_sel = e_pop.rd;
        m_dat = e_pop.data;
        m_we  = (e_pop.rd != 5'd0);
        if (m_we) begin
          wr_log.push_back(int'(e_pop.rd));
          $display("write x%0d = %h", e_pop.rd, e_pop.data);
        end else begin
          $display("drop  x0 entry data %h", e_pop.data);
        end
      end else begin
        m_we = 1'b0;
      end
      if (bus.i_a_valid && pre_a_ok) qa.push_back('{rd: bus.i_a_rd, data: bus.i_a_data});
      if (bus.i_m_valid && pre_m_ok) qm.push_back('{rd: bus.i_m_rd, data: bus.i_m_data});
    end
  end

  // One compare per cycle of every output against the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      checks++;
      if (bus.o_we !== m_we || bus.o_sel_w !== m_sel || bus.o_dat_w !== m_dat ||
          bus.o_busy !== m_busy ||
          bus.o_a_ready !== (qa.size() < FD) || bus.o_m_ready !== (qm.size() < FD) ||
          bus.o_idle !== (qa.size() == 0 && qm.size() == 0 && !m_we)) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got we=%b sel=%0d dat=%h busy=%h ar=%b mr=%b idle=%b required we=%b sel=%0d dat=%h busy=%h ar=%b mr=%b idle=%b",
                 $time, bus.o_we, bus.o_sel_w, bus.o_dat_w, bus.o_busy, bus.o_a_ready,
                 bus.o_m_ready, bus.o_idle, m_we, m_sel, m_dat, m_busy,
                 qa.size() < FD, qm.size() < FD, qa.size() == 0 && qm.size() == 0 && !m_we);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  function automatic logic [XLEN-1:0] pat(input int rd);
    return 64'(rd) * 64'h0101_0101_0101_0101;
  endfunction

  task automatic drive_idle();
    bus.i_a_valid = 1'b0; bus.i_a_rd = '0; bus.i_a_data = '0;
    bus.i_m_valid = 1'b0; bus.i_m_rd = '0; bus.i_m_data = '0;
    bus.i_issue_valid = 1'b0; bus.i_issue_rd = '0;
  endtask

  // Both sources push n entries as fast as ready allows; payload is held
  // while stalled and advanced only after an observed transfer.
  task automatic run_both(input int a_base, input int m_base, input int n,
                          output bit sa, output bit sm);
    int ai = 0;
    int mi = 0;
    bit af, mf;
    sa = 1'b0;
    sm = 1'b0;
    for (int cyc = 0; cyc < 40 && (ai < n || mi < n); cyc++) begin
      bus.i_a_valid = (ai < n);
      bus.i_a_rd    = 5'(a_base + ai);
      bus.i_a_data  = pat(a_base + ai);
      bus.i_m_valid = (mi < n);
      bus.i_m_rd    = 5'(m_base + mi);
      bus.i_m_data  = pat(m_base + mi);
      af = bus.i_a_valid && bus.o_a_ready;
      mf = bus.i_m_valid && bus.o_m_ready;
      if (bus.i_a_valid && !bus.o_a_ready) sa = 1'b1;
      if (bus.i_m_valid && !bus.o_m_ready) sm = 1'b1;
      step();
      if (af) ai++;
      if (mf) mi++;
    end
    drive_idle();
    chk("run_both_accepted", 64'(ai + mi), 64'(2 * n));
  endtask

  // Expected strict alternation of the two rd ranges.
  task automatic check_alt(input string name, input int start, input bit m_first,
                           input int a_base, input int m_base, input int n);
    int idx;
    chk({name, "_count"}, 64'(wr_log.size() - start), 64'(2 * n));
    for (int k = 0; k < n; k++) begin
      idx = start + 2 * k;
      if (idx + 1 < wr_log.size()) begin
        chk({name, "_first"},  64'(wr_log[idx]),     64'(m_first ? m_base + k : a_base + k));
        chk({name, "_second"}, 64'(wr_log[idx + 1]), 64'(m_first ? a_base + k : m_base + k));
      end
    end
  endtask

  // ---------------- directed scenarios ----------------
  bit sa, sm;
  int log_start;

  initial begin
    drive_idle();
    i_reset = 1'b1;
    repeat (3) step();
    i_reset = 1'b0;

    // Reset state
    chk("rst_we", 64'(bus.o_we), 64'd0);
    chk("rst_sel", 64'(bus.o_sel_w), 64'd0);
    chk("rst_dat", bus.o_dat_w, 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_a_ready", 64'(bus.o_a_ready), 64'd1);
    chk("rst_m_ready", 64'(bus.o_m_ready), 64'd1);
    chk("rst_idle", 64'(bus.o_idle), 64'd1);

    // Single ALU write, x5 reserved beforehand
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd5;
    step();
    bus.i_issue_valid = 1'b0;
    bus.i_a_valid = 1'b1; bus.i_a_rd = 5'd5; bus.i_a_data = 64'h1234;   // cycle 0
    step();                                                            // cycle 1
    bus.i_a_valid = 1'b0;
    chk("single_c1_we", 64'(bus.o_we), 64'd0);
    step();                                                            // cycle 2
    chk("single_we", 64'(bus.o_we), 64'd1);
    chk("single_sel", 64'(bus.o_sel_w), 64'd5);
    chk("single_dat", bus.o_dat_w, 64'h1234);
    chk("single_busy_still", 64'(bus.o_busy[5]), 64'd1);
    step();                                                            // cycle 3
    chk("single_busy_clr", 64'(bus.o_busy[5]), 64'd0);
    chk("single_c3_we", 64'(bus.o_we), 64'd0);

    // Contention, A favored first
    log_start = wr_log.size();
    run_both(1, 9, 4, sa, sm);
    repeat (6) step();
    chk("contend_a_stalled", 64'(sa), 64'd1);
    check_alt("contend", log_start, 1'b0, 1, 9, 4);
    chk("contend_idle", 64'(bus.o_idle), 64'd1);

    // Full M FIFO with held payload; last conflict granted A so M goes first
    log_start = wr_log.size();
    run_both(20, 24, 4, sa, sm);
    repeat (6) step();
    chk("mfull_m_stalled", 64'(sm), 64'd1);
    check_alt("mfull", log_start, 1'b1, 20, 24, 4);

    // rd = 0 entry and rd = 0 issue
    bus.i_a_valid = 1'b1; bus.i_a_rd = 5'd0; bus.i_a_data = 64'hFFFF;
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd0;
    step();
    drive_idle();
    chk("rd0_c1_we", 64'(bus.o_we), 64'd0);
    step();
    chk("rd0_we", 64'(bus.o_we), 64'd0);
    chk("rd0_sel", 64'(bus.o_sel_w), 64'd0);
    chk("rd0_dat", bus.o_dat_w, 64'hFFFF);
    chk("rd0_busy", 64'(bus.o_busy), 64'd0);
    step();
    chk("rd0_c3_we", 64'(bus.o_we), 64'd0);
    chk("rd0_idle", 64'(bus.o_idle), 64'd1);

    // Scoreboard set/clear collision on x7
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd7;
    step();
    bus.i_issue_valid = 1'b0;
    bus.i_a_valid = 1'b1; bus.i_a_rd = 5'd7; bus.i_a_data = 64'h77;
    step();
    bus.i_a_valid = 1'b0;
    step();                                                            // cycle k
    chk("coll_we", 64'(bus.o_we), 64'd1);
    chk("coll_sel", 64'(bus.o_sel_w), 64'd7);
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd7;
    step();                                                            // cycle k+1
    bus.i_issue_valid = 1'b0;
    chk("coll_busy_kept", 64'(bus.o_busy[7]), 64'd1);
    bus.i_a_valid = 1'b1; bus.i_a_rd = 5'd7; bus.i_a_data = 64'h78;
    step();
    bus.i_a_valid = 1'b0;
    repeat (2) step();
    chk("coll_second_dat", bus.o_dat_w, 64'h78);
    step();
    chk("coll_busy_clr", 64'(bus.o_busy[7]), 64'd0);

    // Reset mid-flight
    for (int r = 4; r < 8; r++) begin
      bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'(r);
      step();
    end
    bus.i_issue_valid = 1'b0;
    bus.i_a_valid = 1'b1; bus.i_a_rd = 5'd4; bus.i_a_data = 64'h44;
    bus.i_m_valid = 1'b1; bus.i_m_rd = 5'd6; bus.i_m_data = 64'h66;
    step();
    bus.i_a_rd = 5'd5; bus.i_a_data = 64'h55;
    bus.i_m_rd = 5'd7; bus.i_m_data = 64'h77;
    step();
    drive_idle();
    chk("midrst_busy_pre", 64'(bus.o_busy), 64'h00F0);
    chk("midrst_we_pre", 64'(bus.o_we), 64'd1);
    chk("midrst_idle_pre", 64'(bus.o_idle), 64'd0);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("midrst_we", 64'(bus.o_we), 64'd0);
    chk("midrst_busy", 64'(bus.o_busy), 64'd0);
    chk("midrst_idle", 64'(bus.o_idle), 64'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("midrst_no_stale_we", 64'(bus.o_we), 64'd0);
      chk("midrst_stay_idle", 64'(bus.o_idle), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t required under 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
